dm_cache: RTL
=============

Name: dm_cache

Overview:
- Direct-mapped, write-through, no-write-allocate cache between the CPU data port and slow_mem.
- CPU side is a req/gnt slave; memory side is a req/gnt master that drives slow_mem directly.
- One data word per line; tag, valid and data storage are flops.
- Hides slow_mem latency for read hits; exposes hit/miss statistics.

Parameters:
- AddrWidth, 32, byte-address width on both sides.
- DataWidth, 32, word width; must be a multiple of 8.
- NumLines, 16, number of lines; power of two, at least 2.
- StatWidth, 32, width of the hit/miss counters.
- localparam IdxWidth = $clog2(NumLines).
- localparam OffWidth = $clog2(DataWidth/8).
- localparam TagWidth = AddrWidth-IdxWidth-OffWidth.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- cpu_req_i  in  1  CPU request
- cpu_gnt_o  out  1  one-cycle completion pulse to CPU
- cpu_rw_i  in  1  1=write, 0=read
- cpu_addr_i  in  AddrWidth  byte address, word-aligned
- cpu_wdata_i  in  DataWidth  write data
- cpu_rdata_o  out  DataWidth  read data, valid while cpu_gnt_o=1
- mem_req_o  out  1  request to slow_mem
- mem_gnt_i  in  1  grant from slow_mem
- mem_rw_o  out  1  1=write
- mem_addr_o  out  AddrWidth  address to slow_mem, forwarded unchanged
- mem_wdata_o  out  DataWidth  write data to slow_mem
- mem_rdata_i  in  DataWidth  read data, valid while mem_gnt_i=1
- flush_i  in  1  invalidate all lines
- hit_cnt_o  out  StatWidth  hit counter
- miss_cnt_o  out  StatWidth  miss counter

Behaviour:
- Address split:
  - idx = addr[OffWidth+IdxWidth-1:OffWidth]
  - tag = addr[AddrWidth-1:OffWidth+IdxWidth]
  - offset bits are ignored
- Reset values:
  - state S_IDLE; all valid bits 0
  - cpu_gnt_o, mem_req_o, mem_rw_o = 0
  - cpu_rdata_o, mem_addr_o, mem_wdata_o = 0
  - hit/miss counters 0
  - tag/data arrays need no reset
- S_IDLE:
  - flush_i=1: go S_FLUSH. Flush has priority over a simultaneous cpu_req_i; the request stays pending.
  - else cpu_req_i=1: register rw/addr/wdata, go S_LOOKUP.
- S_FLUSH: clear all valid bits in one cycle, go S_IDLE.
- S_LOOKUP: hit = valid[idx] & (tag_array[idx]==tag).
  - Read hit: load cpu_rdata register from data[idx]; hit_cnt+1; go S_RESP.
  - Read miss: miss_cnt+1; go S_MEM.
  - Write: hit_cnt+1 if hit, else miss_cnt+1; go S_MEM.
- S_MEM:
  - mem_req_o=1, with mem_rw_o/mem_addr_o/mem_wdata_o taken from the registered request and held stable.
  - Wait for mem_gnt_i=1. That cycle is the handshake; go S_RESP, so mem_req_o is 0 in the next cycle.
  - slow_mem returns to idle on that handshake, so it must not see req high again.
  - Read: write mem_rdata_i into data[idx], tag[idx]=tag, valid[idx]=1; cpu_rdata reg = mem_rdata_i.
  - Write hit: data[idx]=wdata. Write miss: arrays unchanged (no allocate).
- S_RESP: cpu_gnt_o=1 for exactly one cycle; go S_IDLE.
  - cpu_rdata_o holds its value until the next read response.
  - cpu_rdata_o is don't-care for writes.
- CPU protocol:
  - CPU holds req/rw/addr/wdata stable until it sees gnt.
  - If req is still high in the cycle after gnt, it is treated as a new request.
- Latency (req rises in cycle 0):
  - Read hit: gnt in cycle 2.
  - Miss or write: gnt one cycle after the mem_gnt_i cycle.
- Counters saturate at all-ones and do not wrap.
- flush_i outside S_IDLE is ignored; the driver holds it until the flush is taken.
- Reset mid-transaction: immediate return to reset values. slow_mem shares rst_ni, so no half-done memory handshake survives.

Decomposition:
- Package cache_pkg holds:
  - state_e enum: S_IDLE, S_FLUSH, S_LOOKUP, S_MEM, S_RESP
  - a helper function for the index/tag split
- Sub-module cache_store: valid/tag/data flop arrays.
  - Asynchronous read by idx.
  - Single write port: we, idx, tag, data.
  - Separate flush input that clears all valid bits.

Test Plan (slow_mem model, Latency=4, NumLines=16):
- Cold read 0x40 (mem word 0xDEADBEEF) -> miss, mem_req_o until the grant, cpu_gnt_o one cycle after mem_gnt_i, rdata 0xDEADBEEF, miss_cnt=1.
- Re-read 0x40 -> no mem_req_o, cpu_gnt_o in cycle 2, rdata 0xDEADBEEF, hit_cnt=1.
- Write 0x40=0x12345678, then read 0x40 -> write goes through to memory; the read hits and returns 0x12345678; slow_mem also holds 0x12345678.
- Write miss to 0x80, then read 0x80 -> write reaches memory and no line is allocated; the read misses (miss_cnt +2).
- Read 0x40, then 0x440 (same idx, different tag), then 0x40 -> three misses; the line ends holding the 0x40 data.
- flush_i together with cpu_req_i (read 0x40, cached) -> S_FLUSH first, then the read misses. Reset asserted during S_MEM -> mem_req_o=0 and valid bits cleared immediately.

Source files
------------

// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - state encoding and address-field helper shared by the dm_cache files
package cache_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FLUSH,
    S_LOOKUP,
    S_MEM,
    S_RESP
  } state_e;

  // Returns `width` bits of a byte address starting at bit `lsb`, zero-extended.
  function automatic logic [63:0] addr_field(input logic [63:0] addr,
                                             input int unsigned lsb,
                                             input int unsigned width);
    logic [63:0] mask;
    mask = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
    return (addr >> lsb) & mask;
  endfunction

endpackage

// File: rtl/cache_store.sv
// rtl/cache_store.sv - valid/tag/data flop arrays with async read, one write port and bulk flush
module cache_store #(
  parameter int unsigned NumLines  = 16,
  parameter int unsigned IdxWidth  = 4,
  parameter int unsigned TagWidth  = 26,
  parameter int unsigned DataWidth = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 i_flush,
  input  logic                 i_we,
  input  logic [IdxWidth-1:0]  i_widx,
  input  logic [TagWidth-1:0]  i_wtag,
  input  logic [DataWidth-1:0] i_wdata,
  input  logic [IdxWidth-1:0]  i_ridx,
  output logic                 o_valid,
  output logic [TagWidth-1:0]  o_tag,
  output logic [DataWidth-1:0] o_data
);

  logic [NumLines-1:0]  r_valid;
  logic [TagWidth-1:0]  r_tag  [NumLines];
  logic [DataWidth-1:0] r_data [NumLines];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid <= '0;
    end else if (i_flush) begin
      r_valid <= '0;
    end else if (i_we) begin
      r_valid[i_widx] <= 1'b1;
    end
  end

  // Tag and data contents are meaningless until the matching valid bit is set.
  always_ff @(posedge clk_i) begin
    if (i_we) begin
      r_tag[i_widx]  <= i_wtag;
      r_data[i_widx] <= i_wdata;
    end
  end

  assign o_valid = r_valid[i_ridx];
  assign o_tag   = r_tag[i_ridx];
  assign o_data  = r_data[i_ridx];

endmodule

// File: rtl/dm_cache.sv
// rtl/dm_cache.sv - direct-mapped write-through, no-write-allocate cache in front of slow_mem
module dm_cache
  import cache_pkg::*;
#(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned NumLines  = 16,
  parameter int unsigned StatWidth = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 cpu_req_i,
  output logic                 cpu_gnt_o,
  input  logic                 cpu_rw_i,
  input  logic [AddrWidth-1:0] cpu_addr_i,
  input  logic [DataWidth-1:0] cpu_wdata_i,
  output logic [DataWidth-1:0] cpu_rdata_o,
  output logic                 mem_req_o,
  input  logic                 mem_gnt_i,
  output logic                 mem_rw_o,
  output logic [AddrWidth-1:0] mem_addr_o,
  output logic [DataWidth-1:0] mem_wdata_o,
  input  logic [DataWidth-1:0] mem_rdata_i,
  input  logic                 flush_i,
  output logic [StatWidth-1:0] hit_cnt_o,
  output logic [StatWidth-1:0] miss_cnt_o
);

  localparam int unsigned IdxWidth = $clog2(NumLines);
  localparam int unsigned OffWidth = $clog2(DataWidth / 8);
  localparam int unsigned TagWidth = AddrWidth - IdxWidth - OffWidth;

  state_e               r_state, w_next;
  logic                 r_rw, r_hit;
  logic [AddrWidth-1:0] r_addr;
  logic [DataWidth-1:0] r_wdata, r_rdata;
  logic [StatWidth-1:0] r_hit_cnt, r_miss_cnt;

  logic [IdxWidth-1:0]  w_idx;
  logic [TagWidth-1:0]  w_tag, w_tag_q;
  logic [DataWidth-1:0] w_data_q, w_store_wdata;
  logic                 w_valid_q, w_hit, w_we, w_flush, w_take;

  assign w_idx = IdxWidth'(addr_field(64'(r_addr), OffWidth, IdxWidth));
  assign w_tag = TagWidth'(addr_field(64'(r_addr), OffWidth + IdxWidth, TagWidth));
  assign w_hit = w_valid_q && (w_tag_q == w_tag);
  assign w_take = (r_state == S_IDLE) && !flush_i && cpu_req_i;
  // A read fill stores memory data; a write hit refreshes the line with the CPU data.
  assign w_store_wdata = r_rw ? r_wdata : mem_rdata_i;

  cache_store #(
    .NumLines (NumLines),
    .IdxWidth (IdxWidth),
    .TagWidth (TagWidth),
    .DataWidth(DataWidth)
  ) u_store (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .i_flush(w_flush),
    .i_we   (w_we),
    .i_widx (w_idx),
    .i_wtag (w_tag),
    .i_wdata(w_store_wdata),
    .i_ridx (w_idx),
    .o_valid(w_valid_q),
    .o_tag  (w_tag_q),
    .o_data (w_data_q)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_we      = 1'b0;
    w_flush   = 1'b0;
    cpu_gnt_o = 1'b0;
    mem_req_o = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (flush_i)        w_next = S_FLUSH;
        else if (cpu_req_i) w_next = S_LOOKUP;
      end
      S_FLUSH: begin
        w_flush = 1'b1;
        w_next  = S_IDLE;
      end
      S_LOOKUP: w_next = (w_hit && !r_rw) ? S_RESP : S_MEM;
      S_MEM: begin
        mem_req_o = 1'b1;
        if (mem_gnt_i) begin
          w_we   = !r_rw || r_hit;
          w_next = S_RESP;
        end
      end
      S_RESP: begin
        cpu_gnt_o = 1'b1;
        w_next    = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rw       <= 1'b0;
      r_hit      <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else begin
      if (w_take) begin
        r_rw    <= cpu_rw_i;
        r_addr  <= cpu_addr_i;
        r_wdata <= cpu_wdata_i;
      end
      if (r_state == S_LOOKUP) begin
        r_hit <= w_hit;
        if (w_hit) begin
          if (!r_rw) r_rdata <= w_data_q;
          if (!(&r_hit_cnt)) r_hit_cnt <= r_hit_cnt + StatWidth'(1);
        end else if (!(&r_miss_cnt)) begin
          r_miss_cnt <= r_miss_cnt + StatWidth'(1);
        end
      end
      if ((r_state == S_MEM) && mem_gnt_i && !r_rw) r_rdata <= mem_rdata_i;
    end
  end

  assign cpu_rdata_o = r_rdata;
  assign mem_rw_o    = r_rw;
  assign mem_addr_o  = r_addr;
  assign mem_wdata_o = r_wdata;
  assign hit_cnt_o   = r_hit_cnt;
  assign miss_cnt_o  = r_miss_cnt;

endmodule
